// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 decrypt core:
//   - FSM state encoding (IDLE, EXPAND, ROUND, DONE)
//   - Nr constant and the rcon table (rounds 1..10)
//   - GF(2^8) arithmetic, S-box / inverse S-box
//   - Inverse round blocks: inv_shift_rows, inv_sub_bytes,
//     inv_mix_columns, add_round_key
// Byte ordering everywhere: byte 0 of a 128-bit block sits at bits [127:120],
// byte index = row + 4*column.
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam logic [3:0] AES_NR = 4'd10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } aes_state_e;

    // Round constant for key-schedule step i (1..10); index 0 is unused.
    function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] a2, a3, a12, a15, a240;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a12  = gmul(gmul(a3, a3), gmul(a3, a3));
        a15  = gmul(a12, a3);
        a240 = gmul(a15, a15);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        return gmul(gmul(a240, a12), a2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = ginv(x);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    // Row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_128_decrypt_core_key_step.sv
// -----------------------------------------------------------------------------
// aes_key_step
// Single-round AES-128 key-schedule step, purely combinational.
//   inv_i  : 0 = forward  K(i-1) -> K(i)
//            1 = inverse  K(i)   -> K(i-1)
//   key_i  : current round key
//   rcon_i : round constant of step i
//   key_o  : neighbouring round key
// Both directions share one SubWord(RotWord()) path; only its input word
// differs (w3 forward, w3^w2 inverse, which is the previous key's w3).
// -----------------------------------------------------------------------------
module aes_key_step
    import aes_pkg::*;
(
    input  logic         inv_i,
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] key_o
);

    logic [31:0] w0_s, w1_s, w2_s, w3_s;
    logic [31:0] sel_s, rot_s, t_s;

    // Forward or inverse word recurrence around a shared SubWord.
    always_comb begin
        w0_s  = key_i[127:96];
        w1_s  = key_i[95:64];
        w2_s  = key_i[63:32];
        w3_s  = key_i[31:0];
        sel_s = inv_i ? (w3_s ^ w2_s) : w3_s;
        rot_s = {sel_s[23:0], sel_s[31:24]};
        t_s   = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])}
              ^ {rcon_i, 24'h000000};
        if (inv_i) begin
            key_o = {w0_s ^ t_s, w1_s ^ w0_s, w2_s ^ w1_s, w3_s ^ w2_s};
        end else begin
            key_o[127:96] = w0_s ^ t_s;
            key_o[95:64]  = w1_s ^ w0_s ^ t_s;
            key_o[63:32]  = w2_s ^ w1_s ^ w0_s ^ t_s;
            key_o[31:0]   = w3_s ^ w2_s ^ w1_s ^ w0_s ^ t_s;
        end
    end

endmodule

// File: rtl/aes_128_decrypt_core.sv
// -----------------------------------------------------------------------------
// aes_128_decrypt_core
// Iterative AES-128 decryption: 10 edges of forward key expansion to reach
// K10, then 10 inverse rounds that walk the key schedule backwards in place.
// Accept-to-result latency is 20 edges.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid_i/in_ready_o input handshake (ready only in IDLE)
//   in_cipher_i, in_key_i ciphertext and key, byte 0 at [127:120]
//   in_key_reuse_i        reuse stored K10 (only with AES_DEC_KEY_REUSE_EN)
//   out_valid_o/out_ready_i output handshake, held in DONE
//   out_plain_o           plaintext, kept after the handshake
//   busy_o                any state other than IDLE
//
// Optional feature macro: AES_DEC_KEY_REUSE_EN
//   Keeps K10 from the last completed expansion; an accepted block with
//   in_key_reuse_i=1 and a stored key skips EXPAND (10-edge latency).
// -----------------------------------------------------------------------------
module aes_128_decrypt_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_cipher_i,
    input  logic [127:0] in_key_i,
    input  logic         in_key_reuse_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_plain_o,
    output logic         busy_o
);

    aes_state_e   state_q, state_d;
    logic [3:0]   ctr_q, ctr_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] data_q, data_d;
    logic [127:0] out_q, out_d;

    logic         step_inv_s;
    logic [7:0]   step_rcon_s;
    logic [127:0] step_key_s;
    logic [127:0] rnd_s;
    logic [127:0] rnd_mix_s;

`ifdef AES_DEC_KEY_REUSE_EN
    logic [127:0] k10_q, k10_d;
    logic         key_stored_q, key_stored_d;
`else
    logic         unused_reuse_s;
    assign unused_reuse_s = in_key_reuse_i;
`endif

    // In ROUND, counter r selects rcon[11-r] to step K(11-r) back to K(10-r).
    always_comb begin
        step_inv_s = (state_q == ROUND);
        if (state_q == ROUND) begin
            step_rcon_s = rcon_byte(4'd11 - ctr_q);
        end else begin
            step_rcon_s = rcon_byte(ctr_q);
        end
    end

    aes_key_step u_key_step (
        .inv_i  (step_inv_s),
        .key_i  (rk_q),
        .rcon_i (step_rcon_s),
        .key_o  (step_key_s)
    );

    // Inverse round datapath; the round key is the key-step output of this edge.
    always_comb begin
        rnd_s     = add_round_key(inv_sub_bytes(inv_shift_rows(data_q)), step_key_s);
        rnd_mix_s = inv_mix_columns(rnd_s);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        rk_d    = rk_q;
        data_d  = data_q;
        out_d   = out_q;
`ifdef AES_DEC_KEY_REUSE_EN
        k10_d        = k10_q;
        key_stored_d = key_stored_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    data_d  = in_cipher_i;
                    rk_d    = in_key_i;
                    ctr_d   = 4'd1;
                    state_d = EXPAND;
`ifdef AES_DEC_KEY_REUSE_EN
                    if (in_key_reuse_i && key_stored_q) begin
                        data_d  = in_cipher_i ^ k10_q;
                        rk_d    = k10_q;
                        state_d = ROUND;
                    end else begin
                        state_d = EXPAND;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            EXPAND: begin
                rk_d = step_key_s;
                if (ctr_q == AES_NR) begin
                    data_d  = data_q ^ step_key_s;
                    ctr_d   = 4'd1;
                    state_d = ROUND;
`ifdef AES_DEC_KEY_REUSE_EN
                    k10_d        = step_key_s;
                    key_stored_d = 1'b1;
`endif
                end else begin
                    ctr_d = ctr_q + 4'd1;
                end
            end
            ROUND: begin
                rk_d = step_key_s;
                if (ctr_q >= AES_NR) begin
                    // Final round has no InvMixColumns; counter stays saturated.
                    data_d  = rnd_s;
                    out_d   = rnd_s;
                    ctr_d   = AES_NR;
                    state_d = DONE;
                end else begin
                    data_d = rnd_mix_s;
                    ctr_d  = ctr_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Core state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctr_q   <= 4'd0;
            rk_q    <= 128'h0;
            data_q  <= 128'h0;
            out_q   <= 128'h0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            rk_q    <= rk_d;
            data_q  <= data_d;
            out_q   <= out_d;
        end
    end

`ifdef AES_DEC_KEY_REUSE_EN
    // Stored last round key and its validity flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k10_q        <= 128'h0;
            key_stored_q <= 1'b0;
        end else begin
            k10_q        <= k10_d;
            key_stored_q <= key_stored_d;
        end
    end
`endif

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign out_plain_o = out_q;

endmodule

// File: tb/tb_aes_128_decrypt_core.sv
// -----------------------------------------------------------------------------
// tb_aes_128_decrypt_core
// Directed bench for aes_128_decrypt_core using FIPS-197 known-answer vectors.
// -----------------------------------------------------------------------------
module tb_aes_128_decrypt_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_cipher;
    logic [127:0] in_key;
    logic         in_key_reuse;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_plain;
    logic         busy;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    int n_vec = 0;
    int n_err = 0;
    int lat;

    aes_128_decrypt_core dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_cipher_i    (in_cipher),
        .in_key_i       (in_key),
        .in_key_reuse_i (in_key_reuse),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_plain_o    (out_plain),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one block, then count edges after acceptance until out_valid.
    task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                             input logic reuse, input logic scramble, output int latency);
        in_cipher    = ct;
        in_key       = key;
        in_key_reuse = reuse;
        in_valid     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        latency  = 0;
        while (out_valid !== 1'b1 && latency < 40) begin
            if (scramble) begin
                in_cipher    = {$urandom, $urandom, $urandom, $urandom};
                in_key       = {$urandom, $urandom, $urandom, $urandom};
                in_key_reuse = 1'($urandom_range(0, 1));
                in_valid     = 1'b1;
            end
            @(posedge clk); #1;
            latency++;
        end
        in_valid     = 1'b0;
        in_key_reuse = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_cipher    = 128'h0;
        in_key       = 128'h0;
        in_key_reuse = 1'b0;
        out_ready    = 1'b0;

        // Reset state
        #2;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy",      128'(busy),      128'd0);
        chk("rst_out_plain", out_plain,       128'h0);
        #20;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", 128'(in_ready), 128'd1);

        // C.1 with inputs churned every cycle after acceptance, consumer stalled
        run_block(C1_KEY, C1_CT, 1'b0, 1'b1, lat);
        chk("c1_latency", 128'(lat), 128'd20);
        chk("c1_plain",   out_plain, C1_PT);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", 128'(out_valid), 128'd1);
            chk("stall_out_plain", out_plain,       C1_PT);
            chk("stall_in_ready",  128'(in_ready),  128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_out_valid", 128'(out_valid), 128'd0);
        chk("hs_in_ready",  128'(in_ready),  128'd1);
        chk("hs_busy",      128'(busy),      128'd0);
        chk("hs_hold",      out_plain,       C1_PT);

        // App. B with consumer always ready
        run_block(B_KEY, B_CT, 1'b0, 1'b0, lat);
        chk("b_latency", 128'(lat), 128'd20);
        chk("b_plain",   out_plain, B_PT);
        @(posedge clk); #1;
        chk("b_idle", 128'(in_ready), 128'd1);

        // Reset pulse at E12 aborts the block in flight
        in_cipher = C1_CT;
        in_key    = C1_KEY;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_in_ready",  128'(in_ready),  128'd1);
        chk("abort_busy",      128'(busy),      128'd0);
        chk("abort_out_plain", out_plain,       128'h0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        run_block(B_KEY, B_CT, 1'b0, 1'b0, lat);
        chk("post_rst_latency", 128'(lat), 128'd20);
        chk("post_rst_plain",   out_plain, B_PT);
        @(posedge clk); #1;

`ifdef AES_DEC_KEY_REUSE_EN
        // Stored K10 belongs to the App. B key; supplied key is deliberately wrong
        run_block(128'h0, B_CT, 1'b1, 1'b0, lat);
        chk("reuse_latency", 128'(lat), 128'd10);
        chk("reuse_plain",   out_plain, B_PT);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        run_block(C1_KEY, C1_CT, 1'b1, 1'b0, lat);
        chk("reuse_cold_latency", 128'(lat), 128'd20);
        chk("reuse_cold_plain",   out_plain, C1_PT);
        @(posedge clk); #1;
`else
        // Reuse request is ignored: the supplied key is used on the full path
        run_block(C1_KEY, C1_CT, 1'b1, 1'b0, lat);
        chk("noreuse_latency", 128'(lat), 128'd20);
        chk("noreuse_plain",   out_plain, C1_PT);
        @(posedge clk); #1;
`endif
        chk("final_idle", 128'(in_ready), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
